// File: rtl/add_shift_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_shift_mult_ctrl
// Brief    : Control FSM and product accumulator for a sequential add-shift
//            multiplier. Optional macro MULT_SIGNED_EN selects two's
//            complement operands; undefined gives unsigned operation.
// Revision : 1.0 - initial release
// ============================================================================
module add_shift_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               bit_in,
    output logic               ld,
    output logic               shb,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_LOAD = 2'd1;
    localparam logic [1:0]       c_RUN  = 2'd2;
    localparam logic [1:0]       c_DONE = 2'd3;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_m_reg;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_last;
    logic               w_ld;
    logic               w_shb;
    logic               w_done;

    assign w_last = (r_count == c_LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_shb       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_LOAD;
                end
            end
            c_LOAD: begin
                w_ld        = 1'b1;
                w_state_nxt = c_RUN;
            end
            c_RUN: begin
                w_shb = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

`ifdef MULT_SIGNED_EN
    // The final multiplier bit carries negative weight, hence the subtract.
    logic [WIDTH:0] w_hi_ext;
    logic [WIDTH:0] w_m_ext;
    always_comb begin
        w_hi_ext = {r_acc[2*WIDTH-1], r_acc[2*WIDTH-1:WIDTH]};
        w_m_ext  = {r_m_reg[WIDTH-1], r_m_reg};
        if (!bit_in) begin
            w_sum = w_hi_ext;
        end else if (w_last) begin
            w_sum = w_hi_ext - w_m_ext;
        end else begin
            w_sum = w_hi_ext + w_m_ext;
        end
    end
`else
    always_comb begin
        w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, r_m_reg} : '0);
    end
`endif

    // The sum's top bit becomes the new MSB: carry (unsigned) or sign (signed).
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count   <= '0;
            r_m_reg   <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_m_reg <= multiplicand;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ld      = w_ld;
    assign shb     = w_shb;
    assign done    = w_done;
    assign busy    = (r_state != c_IDLE);
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_add_shift_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_shift_mult_ctrl
// Brief    : Self-checking bench for add_shift_mult_ctrl with a timeline-based
//            reference model, directed literal cases and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_shift_mult_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] multiplicand = '0;
    logic [WIDTH-1:0] mplier = '0;
    logic             bit_in;
    logic             ld, shb, busy, done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0] r_sreg = '0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    add_shift_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) u_dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start),
        .multiplicand (multiplicand),
        .bit_in       (bit_in),
        .ld           (ld),
        .shb          (shb),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // Upstream right-shift register stage.
    always @(posedge clk) begin
        if (ld)       r_sreg <= mplier;
        else if (shb) r_sreg <= r_sreg >> 1;
    end
    assign bit_in = r_sreg[0];

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int x, y;
`ifdef MULT_SIGNED_EN
        x = $signed(a);
        y = $signed(b);
`else
        x = a;
        y = b;
`endif
        return 8'(x * y);
    endfunction

    // Model: ph = cycles since the accepted start edge (-1 = idle).
    int         m_ph = -1;
    logic [3:0] m_mcap = '0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_prod = '0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ph   = -1;
            m_prod = '0;
        end else if (m_ph < 0) begin
            if (start) begin
                m_ph   = 0;
                m_mcap = multiplicand;
            end
        end else begin
            if (m_ph == 0) m_pend = ref_mul(m_mcap, mplier);
            m_ph++;
            if (m_ph == WIDTH + 1)      m_prod = m_pend;
            else if (m_ph == WIDTH + 2) m_ph = -1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_outputs", {20'd0, ld, shb, busy, done, product},
                {20'd0, (m_ph == 0), (m_ph >= 1 && m_ph <= WIDTH), (m_ph >= 0),
                 (m_ph == WIDTH + 1), m_prod});
        end
    end

    // Runs one multiply; returns the done latency in edges and the product.
    task automatic do_mult(input logic [3:0] mc, input logic [3:0] mp, input bit poke_busy,
                           output int lat, output logic [7:0] res);
        @(posedge clk); #1;
        start = 1'b1; multiplicand = mc; mplier = mp;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        res = 'x;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (poke_busy && lat == 2) begin
                start = 1'b1; multiplicand = 4'b0001;
            end
            if (poke_busy && lat == 3) start = 1'b0;
            if (done) break;
        end
        if (lat >= 20) chk("done_timeout", 32'(lat), 32'd5);
        res = product;
    endtask

    logic [7:0] exp_a, exp_b, exp_c;
    int lat;
    logic [7:0] res;

    initial begin
`ifdef MULT_SIGNED_EN
        exp_a = 8'h0F; exp_b = 8'h01; exp_c = 8'h00;
`else
        exp_a = 8'h8F; exp_b = 8'hE1; exp_c = 8'h00;
`endif
        #12;
        chk("reset_outputs", {23'd0, ld, shb, busy, done, product}, 32'd0);
        #10 clr_n = 1'b1;
        chk_en = 1'b1;

        do_mult(4'b1101, 4'b1011, 1'b1, lat, res);
        chk("first_latency", 32'(lat), 32'd5);
        chk("first_product_busy_start", 32'(res), 32'(exp_a));

        do_mult(4'b1111, 4'b1111, 1'b0, lat, res);
        chk("back_to_back_latency", 32'(lat), 32'd5);
        chk("all_ones_product", 32'(res), 32'(exp_b));

        do_mult(4'b1010, 4'b0000, 1'b0, lat, res);
        chk("zero_latency", 32'(lat), 32'd5);
        chk("zero_product", 32'(res), 32'(exp_c));

`ifdef MULT_SIGNED_EN
        do_mult(4'b0011, 4'b1011, 1'b0, lat, res);
        chk("signed_neg15", 32'(res), 32'h0000_00F1);
        do_mult(4'b1000, 4'b1000, 1'b0, lat, res);
        chk("signed_pos64", 32'(res), 32'h0000_0040);
`endif

        // Abort during RUN k=2.
        @(posedge clk); #1;
        start = 1'b1; multiplicand = 4'b0111; mplier = 4'b0110;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("abort_outputs", {23'd0, ld, shb, busy, done, product}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        clr_n = 1'b1;

        do_mult(4'b1101, 4'b1011, 1'b0, lat, res);
        chk("after_abort_latency", 32'(lat), 32'd5);
        chk("after_abort_product", 32'(res), 32'(exp_a));

        // Random traffic, including start/operand churn while busy.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            start = 1'b1; multiplicand = 4'($urandom); mplier = 4'($urandom);
            @(posedge clk); #1;
            repeat (WIDTH + 2) begin
                start = 1'($urandom);
                multiplicand = 4'($urandom);
                if ($urandom_range(0, 3) == 0) mplier = 4'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_shift_mult_ctrl.md
Name: add_shift_mult_ctrl

Overview:
Control FSM and accumulator datapath for the sequential add-shift multiplier. Drives load/shift strobes to the upstream multiplier right-shift-register stage and consumes its serial bit output, LSB first. For each multiplier bit, conditionally adds the multiplicand into the high half of a product accumulator, then shifts right. Presents a WIDTH-by-WIDTH product with a start/done handshake to the top level.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clr_n  input  1  reset, asynchronous, active-low.
start  input  1  request a multiply; sampled only in IDLE.
multiplicand  input  WIDTH  multiplicand; captured on the accepted start edge.
bit_in  input  1  serial multiplier bit from the shift-register stage (its bit_out).
ld  output  1  load strobe to the shift-register stage.
shb  output  1  shift strobe to the shift-register stage.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; product is valid in that cycle.
product  output  2*WIDTH  result; held until the next accepted start.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, count=0, accumulator=0, product=0, ld=shb=busy=done=0. Reset asserted mid-operation aborts immediately, with no done pulse.
- States: IDLE, LOAD, RUN, DONE. ld, shb and done are Moore outputs decoded from state.
- IDLE: start=1 at edge E0 -> LOAD. multiplicand is captured into M_reg, the accumulator is cleared, and count=0.
- LOAD (1 cycle): ld=1. The shift stage loads at E1. LOAD -> RUN.
- RUN (exactly WIDTH cycles, k=0..WIDTH-1):
  - shb=1; bit_in equals multiplier bit k.
  - At each edge: sum[WIDTH:0] = acc_hi + (bit_in ? M_reg : 0), zero-extended.
  - Accumulator becomes {sum, acc_lo} >> 1, keeping the lower 2*WIDTH bits. The carry is never lost.
  - count increments. When count==WIDTH-1 at the edge, -> DONE.
- DONE (1 cycle): done=1 and product=accumulator. product is registered at entry to DONE, so it is visible in the same cycle as done. DONE -> IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), counting the start edge as E0. Back-to-back start is accepted in the cycle after DONE.
- start while busy: ignored, with no effect on state, M_reg or product. multiplicand changes while busy have no effect.
- ld and shb are never high together. shb is never high outside RUN.
- Operands of zero still take the full WIDTH+2 cycles.
- All-ones operands produce no overflow: (2**WIDTH-1)**2 fits in 2*WIDTH bits.

Optional Feature:
MULT_SIGNED_EN
- Defined: both operands are two's complement.
- In RUN, the sum uses sign-extended acc_hi and M_reg.
- For k=WIDTH-1 with bit_in=1, M_reg is subtracted instead of added.
- The right shift is arithmetic: bit 2*WIDTH-1 takes the sign of sum.
- product is the signed 2*WIDTH-bit result.
- Undefined: unsigned operation as above. Cycle timing is identical in both builds.

Test Plan:
- The bench models the shift stage as a 4-bit register: it loads on ld, shifts right on shb, and bit_in=reg[0]. WIDTH=4 in all cases.
- Reset: clr_n=0 for 22 ns, then start=1 one cycle, multiplier 4'b1011, multiplicand 4'b1101 -> ld high 1 cycle, shb high exactly 4 cycles, done at E5, product=8'h8F (143).
- Corners: multiplier 4'b1111, multiplicand 4'b1111 -> product=8'hE1. Multiplier 4'b0000, multiplicand 4'b1010 -> product=8'h00, with done still at E5.
- Start while busy: start re-pulsed during RUN with multiplicand changed to 4'b0001 -> ignored, product still 8'h8F. A start pulsed the cycle after done is accepted, and a second result is produced correctly.
- Reset mid-operation: clr_n dropped during RUN (k=2) -> outputs are 0 immediately, no done pulse, and a later start gives a correct result.
- With MULT_SIGNED_EN: multiplier 4'b1011 (-5), multiplicand 4'b0011 (3) -> product=8'hF1 (-15). Multiplier 4'b1000 (-8), multiplicand 4'b1000 (-8) -> product=8'h40 (64).
